// File: rtl/exec_unit_if.sv
// rtl/exec_unit_if.sv - decoder-to-execute handshake and register file write port bundle
interface exec_unit_if #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
);
    logic             in_valid;
    logic             in_ready;
    logic [2:0]       op;
    logic [WIDTH-1:0] operand_a;
    logic [WIDTH-1:0] operand_b;
    logic [AW-1:0]    dest;
    logic             do_write;
    logic [AW-1:0]    reg_write;
    logic [WIDTH-1:0] write_data;
    logic             zero_flag;
    logic             carry_flag;

    modport master (
        output in_valid, op, operand_a, operand_b, dest,
        input  in_ready, do_write, reg_write, write_data, zero_flag, carry_flag
    );

    modport slave (
        input  in_valid, op, operand_a, operand_b, dest,
        output in_ready, do_write, reg_write, write_data, zero_flag, carry_flag
    );
endinterface

// File: rtl/exec_unit.sv
// rtl/exec_unit.sv - execute stage: single-cycle ALU plus sequenced shift-left and shift-add multiply
module exec_unit #(
    parameter int WIDTH = 8,
    parameter int AW    = 2
) (
    input logic        clk,
    input logic        reset,
    exec_unit_if.slave bus
);
    localparam int SW = $clog2(WIDTH);
    localparam int CW = SW + 1;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_AND = 3'b010;
    localparam logic [2:0] OP_OR  = 3'b011;
    localparam logic [2:0] OP_XOR = 3'b100;
    localparam logic [2:0] OP_SHL = 3'b101;
    localparam logic [2:0] OP_MUL = 3'b110;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_MUL
    } state_t;

    state_t             state_q;
    logic [WIDTH-1:0]   shreg_q;
    logic [2*WIDTH-1:0] mcand_q;
    logic [2*WIDTH-1:0] acc_q;
    logic [CW-1:0]      cnt_q;
    logic [AW-1:0]      dest_q;
    logic               do_write_q;
    logic [AW-1:0]      reg_write_q;
    logic [WIDTH-1:0]   write_data_q;
    logic               zero_flag_q;
    logic               carry_flag_q;

    logic [WIDTH-1:0]   alu_res_d;
    logic               alu_carry_d;
    logic               alu_single_d;
    logic [WIDTH:0]     sum_d;
    logic [WIDTH:0]     diff_d;
    logic [SW-1:0]      shamt_d;
    logic [WIDTH-1:0]   shift_next_d;
    logic               shift_out_d;
    logic [2*WIDTH-1:0] acc_d;

    assign sum_d        = {1'b0, bus.operand_a} + {1'b0, bus.operand_b};
    assign diff_d       = {1'b0, bus.operand_a} - {1'b0, bus.operand_b};
    assign shamt_d      = bus.operand_b[SW-1:0];
    assign shift_next_d = {shreg_q[WIDTH-2:0], 1'b0};
    assign shift_out_d  = shreg_q[WIDTH-1];
    assign acc_d        = acc_q + (shreg_q[0] ? mcand_q : '0);

    // Ops that finish at the accept edge; SHL by zero degenerates to a pass-through.
    always_comb begin
        alu_res_d    = '0;
        alu_carry_d  = 1'b0;
        alu_single_d = 1'b1;
        unique case (bus.op)
            OP_ADD: begin
                alu_res_d   = sum_d[WIDTH-1:0];
                alu_carry_d = sum_d[WIDTH];
            end
            OP_SUB: begin
                alu_res_d   = diff_d[WIDTH-1:0];
                alu_carry_d = diff_d[WIDTH];
            end
            OP_AND: alu_res_d = bus.operand_a & bus.operand_b;
            OP_OR:  alu_res_d = bus.operand_a | bus.operand_b;
            OP_XOR: alu_res_d = bus.operand_a ^ bus.operand_b;
            OP_SHL: begin
                alu_res_d    = bus.operand_a;
                alu_single_d = (shamt_d == '0);
            end
            default: alu_single_d = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q      <= S_IDLE;
            shreg_q      <= '0;
            mcand_q      <= '0;
            acc_q        <= '0;
            cnt_q        <= '0;
            dest_q       <= '0;
            do_write_q   <= 1'b0;
            reg_write_q  <= '0;
            write_data_q <= '0;
            zero_flag_q  <= 1'b0;
            carry_flag_q <= 1'b0;
        end else begin
            do_write_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    if (bus.in_valid) begin
                        dest_q <= bus.dest;
                        if (alu_single_d) begin
                            do_write_q   <= 1'b1;
                            reg_write_q  <= bus.dest;
                            write_data_q <= alu_res_d;
                            zero_flag_q  <= (alu_res_d == '0);
                            carry_flag_q <= alu_carry_d;
                        end else if (bus.op == OP_SHL) begin
                            state_q <= S_SHIFT;
                            shreg_q <= bus.operand_a;
                            cnt_q   <= {1'b0, shamt_d};
                        end else if (bus.op == OP_MUL) begin
                            state_q <= S_MUL;
                            shreg_q <= bus.operand_b;
                            mcand_q <= {{WIDTH{1'b0}}, bus.operand_a};
                            acc_q   <= '0;
                            cnt_q   <= CW'(WIDTH);
                        end
                    end
                end
                S_SHIFT: begin
                    shreg_q <= shift_next_d;
                    cnt_q   <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q      <= S_IDLE;
                        do_write_q   <= 1'b1;
                        reg_write_q  <= dest_q;
                        write_data_q <= shift_next_d;
                        zero_flag_q  <= (shift_next_d == '0);
                        carry_flag_q <= shift_out_d;
                    end
                end
                S_MUL: begin
                    // One multiplier bit per edge, LSB first, multiplicand walks left.
                    acc_q   <= acc_d;
                    mcand_q <= {mcand_q[2*WIDTH-2:0], 1'b0};
                    shreg_q <= {1'b0, shreg_q[WIDTH-1:1]};
                    cnt_q   <= cnt_q - 1'b1;
                    if (cnt_q == CW'(1)) begin
                        state_q      <= S_IDLE;
                        do_write_q   <= 1'b1;
                        reg_write_q  <= dest_q;
                        write_data_q <= acc_d[WIDTH-1:0];
                        zero_flag_q  <= (acc_d[WIDTH-1:0] == '0);
                        carry_flag_q <= |acc_d[2*WIDTH-1:WIDTH];
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign bus.in_ready   = (state_q == S_IDLE) && reset;
    assign bus.do_write   = do_write_q;
    assign bus.reg_write  = reg_write_q;
    assign bus.write_data = write_data_q;
    assign bus.zero_flag  = zero_flag_q;
    assign bus.carry_flag = carry_flag_q;
endmodule

// File: tb/tb_exec_unit.sv
// tb/tb_exec_unit.sv - directed and randomized checks of exec_unit against an arithmetic reference model
module tb_exec_unit;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    logic [1:0] m_reg;
    logic [7:0] m_data;
    logic       m_z;
    logic       m_c;

    exec_unit_if #(.WIDTH(8), .AW(2)) bus ();

    exec_unit #(.WIDTH(8), .AW(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one op to an idle unit, watch 12 cycles, compare against plain arithmetic.
    task automatic run_op(input logic [2:0] o, input logic [7:0] a, input logic [7:0] b,
                          input logic [1:0] d, input bit hold);
        int  r, n, lat, writes, busy, seen_k;
        bit  wr;
        logic [7:0] ed;
        logic ec;
        wr = 1'b1; ec = 1'b0; lat = 1; ed = 8'h00;
        case (o)
            3'd0: begin r = int'(a) + int'(b); ed = r[7:0]; ec = (r > 255); end
            3'd1: begin r = int'(a) - int'(b); ed = r[7:0]; ec = (a < b); end
            3'd2: ed = a & b;
            3'd3: ed = a | b;
            3'd4: ed = a ^ b;
            3'd5: begin
                n = int'(b) % 8;
                r = int'(a) << n;
                ed = r[7:0];
                ec = (n > 0) ? r[8] : 1'b0;
                lat = n + 1;
            end
            3'd6: begin r = int'(a) * int'(b); ed = r[7:0]; ec = (r > 255); lat = 9; end
            default: begin wr = 1'b0; lat = 0; end
        endcase

        chk("ready_before_accept", bus.in_ready, 1);
        bus.in_valid = 1'b1; bus.op = o; bus.operand_a = a; bus.operand_b = b; bus.dest = d;
        writes = 0; busy = 0; seen_k = 0;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if (bus.do_write) begin
                writes++;
                if (seen_k == 0) seen_k = k;
            end
            if (!bus.in_ready && seen_k == 0) busy++;
            bus.in_valid  = hold && !bus.in_ready;
            bus.operand_a = 8'($urandom);
            bus.operand_b = 8'($urandom);
        end

        if (wr) begin
            m_reg = d; m_data = ed; m_z = (ed == 8'h00); m_c = ec;
        end
        chk("write_count", writes, wr ? 1 : 0);
        chk("write_latency", seen_k, lat);
        chk("busy_cycles", busy, wr ? lat - 1 : 0);
        chk("reg_write", bus.reg_write, m_reg);
        chk("write_data", bus.write_data, m_data);
        chk("zero_flag", bus.zero_flag, m_z);
        chk("carry_flag", bus.carry_flag, m_c);
    endtask

    initial begin
        int writes;
        reset = 1'b0;
        bus.in_valid = 1'b0; bus.op = 3'd7; bus.operand_a = '0; bus.operand_b = '0; bus.dest = '0;
        m_reg = '0; m_data = '0; m_z = 1'b0; m_c = 1'b0;

        // Reset for two cycles, then release.
        tick();
        chk("rst_ready", bus.in_ready, 0);
        tick();
        chk("rst_ready2", bus.in_ready, 0);
        chk("rst_do_write", bus.do_write, 0);
        chk("rst_outputs", {bus.reg_write, bus.write_data, bus.zero_flag, bus.carry_flag}, 0);
        reset = 1'b1;
        tick();
        chk("ready_after_release", bus.in_ready, 1);
        chk("no_write_after_release", bus.do_write, 0);

        // Back-to-back ADD then SUB.
        bus.in_valid = 1'b1; bus.op = 3'd0; bus.operand_a = 8'd200; bus.operand_b = 8'd100; bus.dest = 2'd1;
        tick();
        chk("b2b_pulse1", bus.do_write, 1);
        chk("b2b_p1_fields", {bus.reg_write, bus.write_data, bus.carry_flag, bus.zero_flag}, {2'd1, 8'd44, 1'b1, 1'b0});
        chk("b2b_ready", bus.in_ready, 1);
        bus.op = 3'd1; bus.operand_a = 8'd5; bus.operand_b = 8'd7; bus.dest = 2'd2;
        tick();
        bus.in_valid = 1'b0;
        chk("b2b_pulse2", bus.do_write, 1);
        chk("b2b_p2_fields", {bus.reg_write, bus.write_data, bus.carry_flag, bus.zero_flag}, {2'd2, 8'd254, 1'b1, 1'b0});
        tick();
        chk("b2b_pulse_end", bus.do_write, 0);
        m_reg = 2'd2; m_data = 8'd254; m_z = 1'b0; m_c = 1'b1;

        // Directed cases from the rules.
        run_op(3'd4, 8'h5A, 8'h5A, 2'd3, 1'b0);
        run_op(3'd5, 8'h81, 8'd3, 2'd1, 1'b0);
        run_op(3'd5, 8'h81, 8'd0, 2'd2, 1'b0);
        run_op(3'd5, 8'h81, 8'd8, 2'd2, 1'b0);
        run_op(3'd5, 8'hC1, 8'd7, 2'd0, 1'b0);
        run_op(3'd6, 8'd16, 8'd17, 2'd0, 1'b0);
        run_op(3'd6, 8'd3, 8'd5, 2'd1, 1'b1);
        run_op(3'd6, 8'd255, 8'd255, 2'd3, 1'b1);
        run_op(3'd5, 8'h81, 8'd3, 2'd1, 1'b1);
        run_op(3'd7, 8'h12, 8'h34, 2'd3, 1'b0);

        // Reset lands in the fourth MUL cycle: the op must vanish without a write.
        bus.in_valid = 1'b1; bus.op = 3'd6; bus.operand_a = 8'd200; bus.operand_b = 8'd201; bus.dest = 2'd2;
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        chk("mul_busy_before_abort", bus.in_ready, 0);
        reset = 1'b0;
        #1;
        chk("ready_low_in_reset", bus.in_ready, 0);
        tick();
        chk("abort_outputs", {bus.do_write, bus.reg_write, bus.write_data, bus.zero_flag, bus.carry_flag}, 0);
        reset = 1'b1;
        writes = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (bus.do_write) writes++;
        end
        chk("abort_no_write", writes, 0);
        m_reg = '0; m_data = '0; m_z = 1'b0; m_c = 1'b0;
        run_op(3'd0, 8'd250, 8'd6, 2'd3, 1'b0);
        run_op(3'd7, 8'd0, 8'd0, 2'd0, 1'b1);

        // Randomized ops against the model.
        for (int i = 0; i < 40; i++) begin
            run_op(3'($urandom_range(0, 7)), 8'($urandom), 8'($urandom),
                   2'($urandom), 1'($urandom));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/exec_unit.md
Name: exec_unit

Overview:
- Execute stage directly downstream of the 4-entry, 8-bit register file.
- Consumes the two read operands plus a decoded opcode and destination index, and computes the result.
- Drives the register file write port (do_write / reg_write / write_data) with a one-cycle write pulse.
- Single-cycle ALU ops, plus multi-cycle shift-left and shift-add multiply sequenced by an internal FSM with a valid/ready handshake toward the decoder.

Parameters:
- WIDTH, 8, datapath width; must match the register file data width.
- AW, 2, destination register index width (4 registers).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-low reset (asserted when 0).
- in_valid  input  1  decoder presents an op this cycle.
- in_ready  output  1  unit can accept an op this cycle.
- op  input  3  000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 MUL, 111 NOP.
- operand_a  input  WIDTH  register file data1.
- operand_b  input  WIDTH  register file data2.
- dest  input  AW  destination register index.
- do_write  output  1  register file write enable; one-cycle pulse per result.
- reg_write  output  AW  destination index for the write.
- write_data  output  WIDTH  result value.
- zero_flag  output  1  result of last write was 0.
- carry_flag  output  1  carry/borrow/overflow of last write.

Behaviour:
- Accept: an op is accepted when in_valid && in_ready are high at a rising edge E0.
  - op, operands and dest are captured at E0.
  - Inputs are don't-care afterwards.
- FSM states: IDLE, SHIFT, MUL.
- in_ready = (state == IDLE) && reset high. in_ready is 0 while reset is low.
- All outputs except in_ready are registered.
- Single-cycle ops (ADD/SUB/AND/OR/XOR, and SHL with operand_b[2:0]==0):
  - Result, flags and reg_write are registered at E0; do_write is high for the cycle after E0.
  - State stays IDLE, so back-to-back accepts every cycle are legal.
- Arithmetic:
  - ADD: 9-bit sum; write_data = low 8 bits; carry = bit 8.
  - SUB: a−b mod 256; carry = borrow (a < b unsigned).
  - AND/OR/XOR: carry = 0.
- SHL with n = operand_b[2:0] > 0:
  - IDLE→SHIFT at E0, with a counter loaded to n.
  - Each edge in SHIFT shifts left by 1, fills with 0, records the bit shifted out, and decrements the counter.
  - At edge En (counter reaches 0): result registered, do_write pulses the following cycle, state → IDLE.
  - carry = last bit shifted out. operand_b[7:3] is ignored.
- MUL (unsigned shift-add):
  - IDLE→MUL at E0, with a 16-bit accumulator = 0 and a bit counter = 8.
  - Each edge processes one multiplier bit, LSB first.
  - At E8: write_data = product[7:0]; carry = |product[15:8]; do_write pulses the following cycle; state → IDLE.
- NOP: accepted in one cycle; no do_write; flags and write_data unchanged.
- Flags:
  - zero_flag = (result == 0).
  - zero_flag and carry_flag update only on cycles where a result is registered for a write.
- do_write is never high for two consecutive cycles from one op.
- While do_write is low, write_data and reg_write hold their last values.
- in_valid while busy (SHIFT/MUL): ignored, not captured. The decoder must hold its op until in_ready.
- The result-pulse cycle of a multi-cycle op has in_ready = 1, so a new accept may overlap the pulse.
- Reset low at any edge:
  - state → IDLE; do_write = 0; write_data = 0; reg_write = 0; zero_flag = 0; carry_flag = 0.
  - Counter and accumulator are cleared.
  - An in-flight SHL/MUL is aborted with no write.
- Reset has priority over accept.

Test Plan:
- Reset low for 2 cycles, then high → all outputs 0; in_ready 0 during reset and 1 the cycle after release; no do_write.
- Back-to-back: ADD a=200,b=100,dest=1, then SUB a=5,b=7,dest=2 on consecutive cycles → do_write on two consecutive cycles:
  - first pulse: reg_write=1, data=44, carry=1, zero=0.
  - second pulse: reg_write=2, data=254, carry=1.
- XOR a=0x5A,b=0x5A,dest=3 → data=0, zero=1, carry=0, one-cycle latency.
- SHL a=0x81,b=3:
  - in_ready low for 3 cycles, then do_write with data=0x08, carry=0.
  - SHL a=0x81,b=0 → single-cycle, data=0x81, carry=0.
- MUL a=16,b=17,dest=0:
  - in_ready low 8 cycles; do_write 9 cycles after accept; data=0x10, carry=1.
  - MUL 3×5 → data=15, carry=0.
  - in_valid held high during busy → exactly one write.
- Assert reset at MUL cycle 4 → no do_write ever for that op; the next ADD after release completes normally; a NOP never produces do_write and leaves flags unchanged.
